// File: rtl/bus_dev_pkg.sv
// Shared helpers for the device-side bus port: destination-ID extraction and
// saturating counter increment.
package bus_dev_pkg;
  localparam int CNT_W   = 8;
  localparam int MAX_PKT = 64;
  localparam int MAX_ID  = 16;

  // Destination ID is the top id_w bits of a pckg_sz-bit packet.
  function automatic logic [MAX_ID-1:0] dest_id(input logic [MAX_PKT-1:0] pkt,
                                                input int unsigned pckg_sz,
                                                input int unsigned id_w);
    logic [MAX_PKT-1:0] shifted;
    logic [MAX_ID-1:0]  mask;
    shifted = pkt >> (pckg_sz - id_w);
    mask    = '1;
    mask    = mask >> (MAX_ID - id_w);
    return shifted[MAX_ID-1:0] & mask;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                               input logic en);
    return (en && (cnt != '1)) ? cnt + CNT_W'(1) : cnt;
  endfunction
endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO; head is driven straight from
// storage and reads as zero while empty.
module sync_fifo_fwft #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr_reg;
  logic [AW-1:0]    rptr_reg;
  logic [AW:0]      count_reg;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count_reg == (AW+1)'(DEPTH));
  assign empty = (count_reg == '0);
  // A pop frees the slot the same edge, so a write into a full FIFO is
  // accepted when paired with a read; a read of an empty FIFO never is.
  assign wr_en = wr && (!full || rd);
  assign rd_en = rd && !empty;
  assign rdata = empty ? '0 : mem[rptr_reg];

  always_ff @(posedge clk) begin
    if (!reset && wr_en) mem[wptr_reg] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (wr_en) wptr_reg <= wptr_reg + AW'(1);
      if (rd_en) rptr_reg <= rptr_reg + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end
endmodule

// File: rtl/bus_dev_port.sv
// Device-side bus port: TX queue toward the bus, address-filtered RX queue
// toward the device, plus saturating drop/filter statistics.
module bus_dev_port
  import bus_dev_pkg::*;
#(
  parameter int              PCKG_SZ   = 16,
  parameter int              ID_W      = 4,
  parameter logic [ID_W-1:0] BROADCAST = {ID_W{1'b1}},
  parameter int              DEV_ID    = 0,
  parameter int              DEPTH     = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tx_wr,
  input  logic [PCKG_SZ-1:0] tx_data,
  output logic               tx_full,
  output logic               pndng,
  output logic [PCKG_SZ-1:0] D_pop,
  input  logic               pop,
  input  logic               push,
  input  logic [PCKG_SZ-1:0] D_push,
  output logic               rx_valid,
  output logic [PCKG_SZ-1:0] rx_data,
  input  logic               rx_rd,
  output logic [CNT_W-1:0]   tx_drop_cnt,
  output logic [CNT_W-1:0]   rx_drop_cnt,
  output logic [CNT_W-1:0]   rx_filt_cnt
);
  logic              tx_empty;
  logic              rx_full;
  logic              rx_empty;
  logic [MAX_ID-1:0] dest;
  logic              addr_hit;
  logic [CNT_W-1:0]  tx_drop_reg;
  logic [CNT_W-1:0]  rx_drop_reg;
  logic [CNT_W-1:0]  rx_filt_reg;

  sync_fifo_fwft #(.WIDTH(PCKG_SZ), .DEPTH(DEPTH)) u_tx_fifo (
    .clk(clk), .reset(reset), .wr(tx_wr), .wdata(tx_data), .rd(pop),
    .rdata(D_pop), .full(tx_full), .empty(tx_empty)
  );

  assign dest     = dest_id(MAX_PKT'(D_push), PCKG_SZ, ID_W);
  assign addr_hit = push && ((dest == MAX_ID'(DEV_ID)) || (dest == MAX_ID'(BROADCAST)));

  sync_fifo_fwft #(.WIDTH(PCKG_SZ), .DEPTH(DEPTH)) u_rx_fifo (
    .clk(clk), .reset(reset), .wr(addr_hit), .wdata(D_push), .rd(rx_rd),
    .rdata(rx_data), .full(rx_full), .empty(rx_empty)
  );

  assign pndng    = !tx_empty;
  assign rx_valid = !rx_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_drop_reg <= '0;
      rx_drop_reg <= '0;
      rx_filt_reg <= '0;
    end else begin
      tx_drop_reg <= sat_inc(tx_drop_reg, tx_wr && tx_full && !pop);
      rx_drop_reg <= sat_inc(rx_drop_reg, addr_hit && rx_full && !rx_rd);
      rx_filt_reg <= sat_inc(rx_filt_reg, push && !addr_hit);
    end
  end

  assign tx_drop_cnt = tx_drop_reg;
  assign rx_drop_cnt = rx_drop_reg;
  assign rx_filt_cnt = rx_filt_reg;
endmodule

// File: tb/tb_bus_dev_port.sv
// Directed and randomized check of bus_dev_port against a queue-based model.
module tb_bus_dev_port;
  localparam int DEPTH  = 8;
  localparam int DEV_ID = 2;

  logic        clk = 1'b0;
  logic        reset, tx_wr, pop, push, rx_rd;
  logic [15:0] tx_data, D_push;
  logic        tx_full, pndng, rx_valid;
  logic [15:0] D_pop, rx_data;
  logic [7:0]  tx_drop_cnt, rx_drop_cnt, rx_filt_cnt;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc_num = 0;

  logic [15:0] txq[$];
  logic [15:0] rxq[$];
  int m_tx_drop, m_rx_drop, m_rx_filt;

  always #5 clk = ~clk;

  bus_dev_port #(.PCKG_SZ(16), .ID_W(4), .BROADCAST(4'hF), .DEV_ID(DEV_ID), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .tx_wr(tx_wr), .tx_data(tx_data), .tx_full(tx_full),
    .pndng(pndng), .D_pop(D_pop), .pop(pop), .push(push), .D_push(D_push),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_rd(rx_rd),
    .tx_drop_cnt(tx_drop_cnt), .rx_drop_cnt(rx_drop_cnt), .rx_filt_cnt(rx_filt_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s cyc=%0d got=%h expected=%h", tag, cyc_num, got, exp);
    end
  endtask

  function automatic int sat(input int c);
    return (c < 255) ? c + 1 : 255;
  endfunction

  // One bus cycle: drive, clock, advance the model, compare every output.
  task automatic cycle(input logic twr, input logic [15:0] tdat, input logic p,
                       input logic ps, input logic [15:0] dps, input logic rrd,
                       input logic rst);
    int  n;
    logic ok_pop, ok_wr, hit;
    reset = rst; tx_wr = twr; tx_data = tdat; pop = p; push = ps; D_push = dps; rx_rd = rrd;
    @(posedge clk);
    cyc_num++;
    if (rst) begin
      txq.delete(); rxq.delete();
      m_tx_drop = 0; m_rx_drop = 0; m_rx_filt = 0;
    end else begin
      n = txq.size();
      ok_pop = p && (n > 0);
      ok_wr  = twr && ((n < DEPTH) || ok_pop);
      if (twr && !ok_wr) m_tx_drop = sat(m_tx_drop);
      if (ok_pop) void'(txq.pop_front());
      if (ok_wr) txq.push_back(tdat);
      n = rxq.size();
      hit = ps && ((dps[15:12] == 4'(DEV_ID)) || (dps[15:12] == 4'hF));
      ok_pop = rrd && (n > 0);
      ok_wr  = hit && ((n < DEPTH) || ok_pop);
      if (ps && !hit) m_rx_filt = sat(m_rx_filt);
      if (hit && !ok_wr) m_rx_drop = sat(m_rx_drop);
      if (ok_pop) void'(rxq.pop_front());
      if (ok_wr) rxq.push_back(dps);
    end
    #1;
    check("pndng",    32'(pndng),    32'(txq.size() > 0));
    check("D_pop",    32'(D_pop),    32'(txq.size() > 0 ? txq[0] : 16'h0));
    check("tx_full",  32'(tx_full),  32'(txq.size() == DEPTH));
    check("rx_valid", 32'(rx_valid), 32'(rxq.size() > 0));
    check("rx_data",  32'(rx_data),  32'(rxq.size() > 0 ? rxq[0] : 16'h0));
    check("tx_drop",  32'(tx_drop_cnt), 32'(m_tx_drop));
    check("rx_drop",  32'(rx_drop_cnt), 32'(m_rx_drop));
    check("rx_filt",  32'(rx_filt_cnt), 32'(m_rx_filt));
    $display("[TB] cyc %0d rst=%b wr=%b/%h pop=%b push=%b/%h rd=%b -> pndng=%b D_pop=%h full=%b rxv=%b rx=%h cnt=%0d/%0d/%0d",
             cyc_num, rst, twr, tdat, p, ps, dps, rrd, pndng, D_pop, tx_full,
             rx_valid, rx_data, tx_drop_cnt, rx_drop_cnt, rx_filt_cnt);
  endtask

  task automatic idle();
    cycle(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [15:0] d;
    // 1. reset then idle
    cycle(0, 0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 1);
    idle();
    check("rst_pndng", 32'(pndng), 32'd0);
    check("rst_cnt", 32'({tx_drop_cnt, rx_drop_cnt, rx_filt_cnt}), 32'd0);
    // 2. two writes, two pops
    cycle(1, 16'h3A01, 0, 0, 0, 0, 0);
    cycle(1, 16'h5B02, 0, 0, 0, 0, 0);
    check("t2_head", 32'(D_pop), 32'h3A01);
    cycle(0, 0, 1, 0, 0, 0, 0);
    check("t2_pop1", 32'(D_pop), 32'h5B02);
    cycle(0, 0, 1, 0, 0, 0, 0);
    check("t2_empty", 32'({pndng, D_pop}), 32'd0);
    cycle(0, 0, 1, 0, 0, 0, 0);
    // 3. overfill TX, then write+pop while full
    for (int i = 0; i < 10; i++) cycle(1, 16'h1000 + 16'(i), 0, 0, 0, 0, 0);
    check("t3_full", 32'(tx_full), 32'd1);
    check("t3_drop", 32'(tx_drop_cnt), 32'd2);
    cycle(1, 16'h1AAA, 1, 0, 0, 0, 0);
    check("t3_wrpop_full", 32'(tx_full), 32'd1);
    check("t3_wrpop_drop", 32'(tx_drop_cnt), 32'd2);
    check("t3_wrpop_head", 32'(D_pop), 32'h1001);
    for (int i = 0; i < 8; i++) cycle(0, 0, 1, 0, 0, 0, 0);
    // 4. address filter
    cycle(0, 0, 0, 1, 16'h2111, 0, 0);
    cycle(0, 0, 0, 1, 16'hF222, 0, 0);
    cycle(0, 0, 0, 1, 16'h7333, 0, 0);
    check("t4_rx0", 32'(rx_data), 32'h2111);
    cycle(0, 0, 0, 0, 0, 1, 0);
    check("t4_rx1", 32'(rx_data), 32'hF222);
    check("t4_filt", 32'(rx_filt_cnt), 32'd1);
    cycle(0, 0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0, 1, 0);
    // 5. overfill RX, then push+rx_rd while full
    for (int i = 0; i < 9; i++) cycle(0, 0, 0, 1, 16'h2000 + 16'(i), 0, 0);
    check("t5_drop", 32'(rx_drop_cnt), 32'd1);
    cycle(0, 0, 0, 1, 16'h2FFF, 1, 0);
    check("t5_rdpush_drop", 32'(rx_drop_cnt), 32'd1);
    check("t5_rdpush_head", 32'(rx_data), 32'h2001);
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0, 0, 1, 0);
    // 6. reset mid-transfer with pop held
    for (int i = 0; i < 3; i++) cycle(1, 16'h4000 + 16'(i), 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 0, 0);
    cycle(1, 16'h4444, 1, 1, 16'h2555, 1, 1);
    check("t6_pndng", 32'(pndng), 32'd0);
    check("t6_full", 32'(tx_full), 32'd0);
    check("t6_cnt", 32'({tx_drop_cnt, rx_drop_cnt, rx_filt_cnt}), 32'd0);
    // counter saturation
    for (int i = 0; i < 270; i++) cycle(1, 16'h6000 + 16'(i), 0, 1, 16'h5000, 0, 0);
    check("sat_tx", 32'(tx_drop_cnt), 32'hFF);
    check("sat_filt", 32'(rx_filt_cnt), 32'hFF);
    cycle(0, 0, 0, 0, 0, 0, 1);
    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      case ($urandom_range(0, 2))
        0:       d = {4'(DEV_ID), 12'($urandom)};
        1:       d = {4'hF, 12'($urandom)};
        default: d = 16'($urandom);
      endcase
      cycle(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 1)), d, 1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 63) == 0));
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
